// File: rtl/spi_pkg.sv
// Shared FSM state type and edge-counter width for the SPI master.
package spi_pkg;

  localparam int unsigned SPI_EDGE_CNT_W = $clog2(2*32+1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } spi_state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period tick, SCK level and leading/trailing edge strobes for the SPI master.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     shift,
  input  logic                     cpol,
  input  logic [CLK_DIV_WIDTH-1:0] div,
  output logic                     tick_c,
  output logic                     lead_c,
  output logic                     trail_c,
  output logic                     sck
);

  logic [CLK_DIV_WIDTH-1:0] cnt;

  assign tick_c  = en && (cnt == div);
  assign lead_c  = tick_c && shift && (sck == cpol);
  assign trail_c = tick_c && shift && (sck != cpol);

  // Half-period counter restarts from zero whenever the generator is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CLK_DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck <= 1'b0;
    end else if (!en || !shift) begin
      sck <= cpol;
    end else if (tick_c) begin
      sck <= ~sck;
    end
  end

endmodule

// File: rtl/spi_multi_master.sv
// SPI master with multiple chip selects, runtime CPOL/CPHA and clock divider.
// Optional internal loopback port when SPI_LOOPBACK_EN is defined.
module spi_multi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_BIT_WIDTH = 16,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned CLK_DIV_WIDTH  = 4,
  parameter int unsigned LSB_FIRST      = 1,
  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      start,
  input  logic [SEL_W-1:0]          slave_sel,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic [CLK_DIV_WIDTH-1:0]  clk_div,
  input  logic [DATA_BIT_WIDTH-1:0] data_in,
  output logic [DATA_BIT_WIDTH-1:0] data_out,
  output logic                      busy,
  output logic                      valid,
  output logic                      sck,
  output logic                      mosi,
  input  logic                      miso,
  output logic [NUM_SLAVES-1:0]     ss_n
`ifdef SPI_LOOPBACK_EN
  ,
  input  logic                      loopback
`endif
);

  localparam int unsigned EDGES = 2 * DATA_BIT_WIDTH;

  spi_state_e                state, nxt;
  logic [1:0]                rst_sync;
  logic [SEL_W-1:0]          sel_q, sel_d_c;
  logic                      cpol_q, cpha_q, cpol_d_c;
  logic [CLK_DIV_WIDTH-1:0]  div_q;
  logic [DATA_BIT_WIDTH-1:0] tx_q, rx_q;
  logic [SPI_EDGE_CNT_W-1:0] edge_cnt;
  logic                      accept_c, gen_en_c, active_nxt_c, lb_c, rx_bit_c;
  logic                      tick_c, lead_c, trail_c, adv_c, samp_c;
  logic [NUM_SLAVES-1:0]     ss_nxt_c;

  function automatic logic first_bit(input logic [DATA_BIT_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_BIT_WIDTH-1];
  endfunction

  function automatic logic [DATA_BIT_WIDTH-1:0] shift_word(input logic [DATA_BIT_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_BIT_WIDTH-1:0] insert_bit(input logic [DATA_BIT_WIDTH-1:0] w,
                                                           input logic b);
    return (LSB_FIRST != 0) ? {b, w[DATA_BIT_WIDTH-1:1]} : {w[DATA_BIT_WIDTH-2:0], b};
  endfunction

`ifdef SPI_LOOPBACK_EN
  assign lb_c = loopback;
`else
  assign lb_c = 1'b0;
`endif

  // Starts are refused until the reset release has passed through the synchroniser.
  assign accept_c = (state == IDLE) && en && start && rst_sync[1];
  assign gen_en_c = en && ((state == SETUP) || (state == SHIFT) || (state == HOLD));
  assign sel_d_c  = accept_c ? slave_sel : sel_q;
  assign cpol_d_c = accept_c ? cpol : cpol_q;
  assign adv_c    = cpha_q ? lead_c : trail_c;
  assign samp_c   = cpha_q ? trail_c : lead_c;
  assign rx_bit_c = lb_c ? mosi : miso;

  spi_sck_gen #(
    .CLK_DIV_WIDTH(CLK_DIV_WIDTH)
  ) u_sck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (gen_en_c),
    .shift  (state == SHIFT),
    .cpol   (cpol_d_c),
    .div    (div_q),
    .tick_c (tick_c),
    .lead_c (lead_c),
    .trail_c(trail_c),
    .sck    (sck)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt          = state;
    active_nxt_c = 1'b0;
    ss_nxt_c     = '1;
    case (state)
      IDLE:    if (accept_c) nxt = SETUP;
      SETUP:   if (tick_c) nxt = SHIFT;
      SHIFT:   if (tick_c && (edge_cnt == SPI_EDGE_CNT_W'(EDGES - 1))) nxt = HOLD;
      HOLD:    if (tick_c) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (!en) nxt = IDLE;
    active_nxt_c = (nxt == SETUP) || (nxt == SHIFT) || (nxt == HOLD);
    if (active_nxt_c && !lb_c) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (sel_d_c == SEL_W'(i)) ss_nxt_c[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '0;
      sel_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      div_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      edge_cnt <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= '1;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
      busy     <= (nxt != IDLE);
      valid    <= (nxt == DONE);
      ss_n     <= ss_nxt_c;
      if (state != SHIFT) begin
        edge_cnt <= '0;
      end else if (tick_c) begin
        edge_cnt <= edge_cnt + SPI_EDGE_CNT_W'(1);
      end
      // With cpha=0 the first bit is presented before the first SCK edge.
      if (accept_c) begin
        sel_q  <= slave_sel;
        cpol_q <= cpol;
        cpha_q <= cpha;
        div_q  <= clk_div;
        tx_q   <= cpha ? data_in : shift_word(data_in);
        mosi   <= cpha ? 1'b0 : first_bit(data_in);
        rx_q   <= '0;
      end else begin
        if (adv_c) tx_q <= shift_word(tx_q);
        if (samp_c) rx_q <= insert_bit(rx_q, rx_bit_c);
        if (!active_nxt_c) begin
          mosi <= 1'b0;
        end else if (adv_c) begin
          mosi <= first_bit(tx_q);
        end
      end
      if (nxt == DONE) data_out <= rx_q;
    end
  end

endmodule

// File: doc/spi_multi_master.md
SPI_MULTI_MASTER -- requirements
Module: spi_multi_master

Interface
REQ-001 The block SHALL have parameter DATA_BIT_WIDTH, default 16, meaning word length in bits, legal range 2..32.
REQ-002 The block SHALL have parameter NUM_SLAVES, default 4, meaning the number of chip-select lines, legal range 1..8.
REQ-003 The block SHALL have parameter CLK_DIV_WIDTH, default 4, meaning the width of the clk_div input.
REQ-004 The block SHALL have parameter LSB_FIRST, default 1, meaning 1 = bit 0 shifted first and 0 = MSB shifted first.
REQ-005 The block SHALL have these ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable; low aborts any transfer.
- start  input  1  one-cycle request; sampled only in IDLE.
- slave_sel  input  max(1,$clog2(NUM_SLAVES))  target slave index.
- cpol  input  1  SCK idle level.
- cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
- clk_div  input  CLK_DIV_WIDTH  half-period = clk_div+1 clk cycles.
- data_in  input  DATA_BIT_WIDTH  word to transmit.
- data_out  output  DATA_BIT_WIDTH  last received word.
- busy  output  1  high from the start-acceptance edge until DONE exits.
- valid  output  1  one-cycle completion pulse.
- sck  output  1  serial clock.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.
- ss_n  output  NUM_SLAVES  active-low chip selects.

Function
REQ-006 On the clk edge where start=1, en=1 and state=IDLE, slave_sel, cpol, cpha, clk_div and data_in SHALL be latched, and later input changes SHALL have no effect until the next IDLE.
REQ-007 A start pulse arriving outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-008 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD and DONE, with transitions:
- IDLE->SETUP on an accepted start.
- SETUP->SHIFT after one half-period.
- SHIFT->HOLD after 2*DATA_BIT_WIDTH half-periods.
- HOLD->DONE after one half-period.
- DONE->IDLE after one cycle.
REQ-009 ss_n[sel] SHALL be low in SETUP, SHIFT and HOLD, and all other ss_n bits SHALL remain high.
REQ-010 A slave_sel value >= NUM_SLAVES SHALL cause the transfer to run with all ss_n lines high.
REQ-011 sck SHALL equal the latched cpol outside SHIFT and SHALL toggle once per half-period in SHIFT, producing exactly DATA_BIT_WIDTH full pulses.
REQ-012 With cpha=0, the first bit SHALL be on mosi from SETUP entry, miso SHALL be sampled on each leading edge, and mosi SHALL advance on each trailing edge.
REQ-013 With cpha=1, mosi SHALL advance on each leading edge and miso SHALL be sampled on each trailing edge.
REQ-014 Received bits SHALL be assembled in the same bit order as transmitted, per LSB_FIRST.
REQ-015 mosi SHALL be 0 outside SETUP, SHIFT and HOLD.
REQ-016 busy SHALL be high for exactly (2*DATA_BIT_WIDTH+2)*(clk_div+1)+1 cycles per transfer, starting on the cycle after acceptance.
REQ-017 In DONE, data_out SHALL be loaded with the received word and valid SHALL be 1 for exactly one cycle.
REQ-018 data_out SHALL hold its value until the next DONE.
REQ-019 When en=0, the next clk edge SHALL force IDLE, all ss_n high, sck=cpol and mosi=0.
REQ-020 A transfer aborted by en=0 SHALL NOT pulse valid, and data_out SHALL be unchanged.
REQ-021 With clk_div=0, sck SHALL run at clk/2.

Reset
REQ-022 While rst_n=0, the block SHALL be in IDLE with busy=0, valid=0, data_out=0, sck=0, mosi=0 and ss_n all ones.
REQ-023 While rst_n=0, the latched cpol SHALL be 0.
REQ-024 Assertion of rst_n mid-transfer SHALL take effect immediately, asynchronously, and SHALL NOT pulse valid.
REQ-025 Deassertion of rst_n SHALL be synchronised so that the first accepted start is at least two cycles after release.

Configuration
REQ-026 With macro SPI_LOOPBACK_EN defined, the block SHALL add input port loopback (1 bit); when loopback=1, the receive path SHALL sample internal mosi instead of miso, and ss_n SHALL be forced all high.
REQ-027 Without SPI_LOOPBACK_EN, the loopback port and its logic SHALL be absent.

Structure
REQ-028 A shared package spi_pkg SHALL hold the FSM state enumeration and the constant SPI_EDGE_CNT_W = $clog2(2*32+1).
REQ-029 One sub-module, spi_sck_gen, SHALL generate half-period tick, leading-edge and trailing-edge strobes from clk_div and cpol.
REQ-030 spi_sck_gen SHALL be enabled only in SETUP, SHIFT and HOLD.

Verification
REQ-031 The bench SHALL run W=16, clk_div=0, cpol=0, cpha=0, data_in=0xA5C3, with miso looped from mosi; required response: busy high 35 cycles, valid pulse, data_out=0xA5C3, ss_n[sel] low only during the transfer.
REQ-032 The bench SHALL sweep all four cpol/cpha modes against a slave model returning 0x1234; required response: data_out=0x1234 in every mode and sck idle level equal to cpol.
REQ-033 The bench SHALL run clk_div=3 with slave_sel=2; required response: sck period 8 clk cycles, only ss_n[2] low, busy for 137 cycles.
REQ-034 The bench SHALL pulse start again mid-transfer; required response: the pulse is ignored, exactly one valid, and the second word is not sent.
REQ-035 The bench SHALL drop en at bit 5 and, separately, assert rst_n=0 at bit 9; required response: immediate IDLE, ss_n=all ones, no valid, and data_out unchanged (en case) or 0 (reset case).
REQ-036 The bench SHALL build with SPI_LOOPBACK_EN, set loopback=1 and send data_in=0x00FF; required response: data_out=0x00FF with ss_n all high throughout.
